toggle_bank: RTL
================

Name: toggle_bank

Overview:
- Parametrised, multi-channel successor to the single-bit enable-driven toggle cell.
- Each of CHANNELS independent channels drives a registered output q. Each channel runs in a per-channel mode selected at run time: off, toggle, divide or one-shot.
- Each channel also drives a one-cycle change strobe z.
- Configuration enters through a valid/ready write port. The block sits beside the existing toggle cell in the simple-circuit test area and is the target for the next round of hardware assertions.

Parameters:
- CHANNELS, 4, number of independent channels (1..16).
- DIV_W, 8, width of per-channel divide/pulse-length value and internal counter.
- RESET_MODE, 1, mode loaded into every channel at reset (0 OFF, 1 TOGGLE, 2 DIVIDE, 3 ONESHOT).
- RESET_DIV, 1, divide/pulse value loaded at reset.
- CH_W, $clog2(CHANNELS) min 1, width of channel select (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel enable/trigger.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_ch  in  CH_W  target channel.
- cfg_mode  in  2  new mode.
- cfg_div  in  DIV_W  new divide/pulse value.
- cfg_err  out  1  one-cycle pulse: accepted write addressed a channel >= CHANNELS.
- q  out  CHANNELS  registered channel outputs.
- z  out  CHANNELS  registered one-cycle strobe, high in exactly the cycles where q[i] differs from its previous value.

Behaviour:
- Reset (reset=0, async):
  - q=0, z=0, cfg_err=0, cfg_ready=0.
  - All counters=0, en history=0, mode=RESET_MODE, div=RESET_DIV.
  - Reset asserted mid-operation clears everything immediately, including an in-flight one-shot.
- Effective divide value: eff_div = (div==0) ? 1 : div.
- Config handshake:
  - cfg_ready rises the first clock edge after reset is released.
  - A write is accepted on the edge where cfg_valid && cfg_ready.
  - cfg_ready is low the following cycle (apply cycle), then high again. Maximum rate is one write per 2 cycles.
  - An accepted write to a valid channel loads mode/div and clears that channel's counter and one-shot state, and forces q[i]=0.
  - z[i]=1 on that update if q[i] was 1.
  - An accepted write with cfg_ch >= CHANNELS changes nothing and pulses cfg_err for 1 cycle.
  - cfg_valid while cfg_ready=0 is ignored; no queueing.
- Priority: a config update to channel i overrides that channel's en activity in the same cycle.
- Mode 0 OFF: q[i] holds; en ignored; counter held at 0.
- Mode 1 TOGGLE: each cycle en[i]=1, q[i] inverts at the next edge. This is identical to the legacy toggle cell.
- Mode 2 DIVIDE:
  - Counter increments on cycles with en[i]=1.
  - When counter == eff_div-1 with en[i]=1, counter returns to 0 and q[i] inverts.
  - en low holds the counter; no wrap beyond eff_div-1.
- Mode 3 ONESHOT:
  - A rising edge of en[i] (en[i]=1, previous-cycle en[i]=0) while idle sets q[i]=1 at the next edge and starts the counter.
  - q[i] stays high for exactly eff_div cycles, then returns to 0.
  - Non-retriggerable: edges while active are ignored.
  - en held high does not re-trigger; it needs a fresh 0->1 transition.
  - en history updates in every mode, so a mode switch does not create a false edge.
- z timing: z[i] is registered alongside q[i] and is high in the same cycle q[i] shows its new value.
- Latency: en to q change is 1 cycle (TOGGLE); config accept to new behaviour is 1 cycle.

Test Plan:
- Reset release, no cfg, CHANNELS=4: toggle en[0] 1,0 eight times -> q[0] alternates 1,0,1,... one cycle after each en=1; z[0] high those same cycles; q[3:1]=0.
- Write ch1 mode=2 div=3, hold en[1]=1 for 12 cycles -> q[1] inverts every 3rd cycle (4 edges); en[1] low for 5 cycles mid-run -> counter frozen, resumes count without a lost step.
- Write ch2 mode=3 div=4, pulse en[2] for 1 cycle, retrigger at pulse cycle 2 -> q[2] high exactly 4 cycles, no extension; en[2] held high 10 cycles -> single pulse.
- Back-to-back cfg_valid -> cfg_ready low on the second cycle and that write is not applied. Write with cfg_ch=5 under CHANNELS=5 -> cfg_err pulse, no state change.
- Write ch0 while q[0]=1 in the same cycle as en[0]=1 -> q[0]=0, z[0]=1, toggle ignored.
- Assert reset low mid one-shot and mid divide -> q, z, cfg_ready=0 immediately; after release, modes equal RESET_MODE/RESET_DIV.

Source files
------------

// File: rtl/toggle_bank.sv
// toggle_bank: multi-channel successor to the single-bit toggle cell.
// Each channel runs OFF / TOGGLE / DIVIDE / ONESHOT, selected at run time
// through a valid/ready config port that accepts at most one write per two cycles.
module toggle_bank #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RESET_MODE = 1,
  parameter int unsigned RESET_DIV  = 1,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] z
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_DIVIDE  = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam mode_e            RST_MODE = mode_e'(RESET_MODE[1:0]);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(RESET_DIV);

  // Registered per-channel state
  mode_e               mode_r   [CHANNELS];
  logic [DIV_W-1:0]    div_r    [CHANNELS];
  logic [DIV_W-1:0]    cnt_r    [CHANNELS];
  logic [CHANNELS-1:0] active_r;
  logic [CHANNELS-1:0] en_d_r;

  // Next-state values
  mode_e               mode_n   [CHANNELS];
  logic [DIV_W-1:0]    div_n    [CHANNELS];
  logic [DIV_W-1:0]    cnt_n    [CHANNELS];
  logic [CHANNELS-1:0] active_n;
  logic [CHANNELS-1:0] q_n;
  logic [CHANNELS-1:0] z_n;
  logic                cfg_ready_n;
  logic                cfg_err_n;

  // Decoded helpers
  logic                accept;
  logic                ch_ok;
  logic [CHANNELS-1:0] cfg_hit;
  logic [CHANNELS-1:0] rise;
  logic [DIV_W-1:0]    last_cnt [CHANNELS];

  // Config handshake decode and per-channel terminal count / en edge detect
  always_comb begin
    accept  = cfg_valid && cfg_ready;
    ch_ok   = 32'(cfg_ch) < CHANNELS;
    cfg_hit = '0;
    rise    = en & ~en_d_r;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cfg_hit[i]  = accept && ch_ok && (cfg_ch == CH_W'(i));
      // eff_div - 1, where a programmed divide of zero behaves as one
      last_cnt[i] = (div_r[i] == '0) ? '0 : div_r[i] - DIV_W'(1);
    end
  end

  // Next-state logic: config write overrides mode activity on the addressed channel
  always_comb begin
    cfg_ready_n = ~accept;
    cfg_err_n   = accept && !ch_ok;
    active_n    = active_r;
    q_n         = q;
    z_n         = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      mode_n[i] = mode_r[i];
      div_n[i]  = div_r[i];
      cnt_n[i]  = cnt_r[i];
    end

    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cfg_hit[i]) begin
        mode_n[i]   = mode_e'(cfg_mode);
        div_n[i]    = cfg_div;
        cnt_n[i]    = '0;
        active_n[i] = 1'b0;
        q_n[i]      = 1'b0;
      end else begin
        case (mode_r[i])
          MODE_OFF: begin
            cnt_n[i]    = '0;
            active_n[i] = 1'b0;
          end
          MODE_TOGGLE: begin
            cnt_n[i]    = '0;
            active_n[i] = 1'b0;
            if (en[i]) q_n[i] = ~q[i];
          end
          MODE_DIVIDE: begin
            active_n[i] = 1'b0;
            if (en[i]) begin
              if (cnt_r[i] >= last_cnt[i]) begin
                cnt_n[i] = '0;
                q_n[i]   = ~q[i];
              end else begin
                cnt_n[i] = cnt_r[i] + DIV_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            if (active_r[i]) begin
              // Pulse in flight: count out eff_div high cycles, ignore new edges
              if (cnt_r[i] >= last_cnt[i]) begin
                cnt_n[i]    = '0;
                active_n[i] = 1'b0;
                q_n[i]      = 1'b0;
              end else begin
                cnt_n[i] = cnt_r[i] + DIV_W'(1);
              end
            end else if (rise[i]) begin
              cnt_n[i]    = '0;
              active_n[i] = 1'b1;
              q_n[i]      = 1'b1;
            end
          end
          default: begin
            cnt_n[i] = '0;
          end
        endcase
      end
      z_n[i] = q_n[i] ^ q[i];
    end
  end

  // State register; reset clears outputs and reloads power-on modes immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      q         <= '0;
      z         <= '0;
      active_r  <= '0;
      en_d_r    <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        mode_r[i] <= RST_MODE;
        div_r[i]  <= RST_DIV;
        cnt_r[i]  <= '0;
      end
    end else begin
      cfg_ready <= cfg_ready_n;
      cfg_err   <= cfg_err_n;
      q         <= q_n;
      z         <= z_n;
      active_r  <= active_n;
      en_d_r    <= en;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        mode_r[i] <= mode_n[i];
        div_r[i]  <= div_n[i];
        cnt_r[i]  <= cnt_n[i];
      end
    end
  end

endmodule
